// File: rtl/vga_pkg.sv
// Shared timing defaults, counter width and recovery FSM states for the VGA sync receiver.
package vga_pkg;

  localparam int CNT_W         = 11;
  localparam int H_ACT_OFS_DEF = 144;
  localparam int H_ACT_DEF     = 640;
  localparam int V_ACT_OFS_DEF = 34;
  localparam int V_ACT_DEF     = 480;
  localparam int TIMEOUT_DEF   = 4096;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } rx_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Edge detector for one active-low sync line; VGA_SYNC_RX_META_EN inserts a
// 2-flop synchronizer (idle high) ahead of the history flop.
module vga_sync_edge #(
  parameter bit RISING = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sync,
  output logic o_edge
);

  logic cur;
  logic hist_q, hist_d;

`ifdef VGA_SYNC_RX_META_EN
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_sync;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign cur = sync_q;
`else
  assign cur = i_sync;
`endif

  always_comb hist_d = cur;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 1'b1;
    else       hist_q <= hist_d;
  end

  assign o_edge = RISING ? (~hist_q & cur) : (hist_q & ~cur);

endmodule

// File: rtl/vga_sync_rx.sv
// VGA timing recovery: rebuilds pixel/line counters from HSYNC/VSYNC, measures
// line/frame length and reports lock. Define VGA_SYNC_RX_META_EN for async sources.
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int H_ACT_OFS = H_ACT_OFS_DEF,
  parameter int H_ACT     = H_ACT_DEF,
  parameter int V_ACT_OFS = V_ACT_OFS_DEF,
  parameter int V_ACT     = V_ACT_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_active,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic [10:0] o_h_total,
  output logic [10:0] o_v_total
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_ACT_OFS);
  localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_ACT_OFS + H_ACT - 1);
  localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_ACT_OFS);
  localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_ACT_OFS + V_ACT - 1);

  logic hs_fall, vs_rise;

  vga_sync_edge #(.RISING(1'b0)) u_hs_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sync (i_hs),
    .o_edge (hs_fall)
  );

  vga_sync_edge #(.RISING(1'b1)) u_vs_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sync (i_vs),
    .o_edge (vs_rise)
  );

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  rx_state_e        state_q, state_d;
  logic [1:0]       frames_ok_q, frames_ok_d;
  logic             mismatch_q, mismatch_d;
  logic             locked_q, locked_d;
  logic             frame_start_q, frame_start_d;

  logic tmo_hit, line_err, frame_ok;

  assign tmo_hit  = (tmo_q == TMO_LIM);
  // The first line after a frame start is excluded: it straddles the frame boundary.
  assign line_err = hs_fall & ~vs_rise & (v_cnt_q != '0) & ((h_cnt_q + 1'b1) != h_total_q);
  assign frame_ok = ((v_cnt_q + 1'b1) == v_total_q);

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path infers a latch.
    h_cnt_d       = hs_fall ? '0 : sat_inc(h_cnt_q);
    h_total_d     = hs_fall ? h_cnt_q + 1'b1 : h_total_q;
    v_cnt_d       = v_cnt_q;
    v_total_d     = v_total_q;
    tmo_d         = hs_fall ? '0 : (tmo_hit ? tmo_q : tmo_q + 1'b1);
    frame_start_d = vs_rise;
    state_d       = state_q;
    frames_ok_d   = frames_ok_q;
    mismatch_d    = mismatch_q;

    // A coincident HSYNC edge is already counted by the +1 below.
    if (vs_rise) begin
      v_cnt_d   = '0;
      v_total_d = v_cnt_q + 1'b1;
    end else if (hs_fall) begin
      v_cnt_d = sat_inc(v_cnt_q);
    end

    if (tmo_hit) begin
      state_d     = SEARCH;
      frames_ok_d = '0;
      mismatch_d  = 1'b0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (vs_rise) begin
            state_d     = MEASURE;
            frames_ok_d = '0;
            mismatch_d  = 1'b0;
          end
        end
        MEASURE: begin
          if (line_err) mismatch_d = 1'b1;
          if (vs_rise) begin
            mismatch_d = 1'b0;
            if (!mismatch_q && frame_ok) begin
              frames_ok_d = frames_ok_q + 1'b1;
              if (frames_ok_q == 2'd1) state_d = LOCKED;
            end else begin
              frames_ok_d = '0;
            end
          end
        end
        LOCKED: begin
          mismatch_d = line_err;
          if (line_err || (vs_rise && !frame_ok)) begin
            state_d     = MEASURE;
            frames_ok_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      tmo_q         <= '0;
      state_q       <= SEARCH;
      frames_ok_q   <= '0;
      mismatch_q    <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      tmo_q         <= tmo_d;
      state_q       <= state_d;
      frames_ok_q   <= frames_ok_d;
      mismatch_q    <= mismatch_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
    end
  end

  logic h_in, v_in;

  assign h_in          = (h_cnt_q >= H_LO) && (h_cnt_q <= H_HI);
  assign v_in          = (v_cnt_q >= V_LO) && (v_cnt_q <= V_HI);
  assign o_x           = h_in ? 10'(h_cnt_q - H_LO) : '0;
  assign o_y           = v_in ? 10'(v_cnt_q - V_LO) : '0;
  assign o_active      = h_in & v_in & locked_q;
  assign o_locked      = locked_q;
  assign o_frame_start = frame_start_q;
  assign o_h_total     = h_total_q;
  assign o_v_total     = v_total_q;

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
Receive-side VGA timing recovery. Samples active-low HSYNC/VSYNC from a timing source on the same pixel clock, rebuilds pixel/line counters, measures line and frame lengths, and reports lock. Sits downstream of the VGA timing generator, e.g. for capture, scaler input or loopback self-test, and presents the same x/y/active view the generator produces.

Parameters:
H_ACT_OFS, 144, clocks from HSYNC assertion (falling edge) to the first active pixel
H_ACT, 640, active pixels per line
V_ACT_OFS, 34, lines from VSYNC deassertion (rising edge) to the first active line
V_ACT, 480, active lines per frame
TIMEOUT, 4096, clocks without an HSYNC falling edge before lock is dropped

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
i_hs  in  1  horizontal sync, active low
i_vs  in  1  vertical sync, active low
o_x  out  10  active pixel x; 0 outside the active window
o_y  out  10  active line y; 0 outside the active window
o_active  out  1  high on active pixels, only while locked
o_locked  out  1  timing stable
o_frame_start  out  1  one-cycle pulse on the VSYNC deassert edge
o_h_total  out  11  last measured line length, in clocks
o_v_total  out  11  last measured frame length, in lines

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset. All state is cleared on reset assertion, independent of clk.
- Reset values: all counters 0; o_x=0, o_y=0, o_active=0, o_locked=0, o_frame_start=0, o_h_total=0, o_v_total=0; FSM in SEARCH; sync history registers set to 1 (idle).
- Edge detection: hs_q and vs_q hold the previous-cycle samples.
  - hs_fall = hs_q & ~i_hs.
  - vs_rise = ~vs_q & i_vs.
- h_cnt (11 bit):
  - On hs_fall: h_cnt<=0 and o_h_total<=h_cnt+1.
  - Otherwise h_cnt increments, saturating at 2047.
- v_cnt (11 bit):
  - Increments on each hs_fall, saturating.
  - On vs_rise: v_cnt<=0 and o_v_total<=v_cnt+1.
  - If vs_rise and hs_fall occur in the same cycle, vs_rise wins: v_cnt<=0, and the counted line is included in o_v_total.
- Latency: a sync edge at input cycle N gives counter=0 at N+1. o_x, o_y and o_active are combinational from the counters and FSM.
- Active window:
  - h_in = h_cnt in [H_ACT_OFS, H_ACT_OFS+H_ACT-1].
  - v_in = v_cnt in [V_ACT_OFS, V_ACT_OFS+V_ACT-1].
  - o_x = h_in ? h_cnt-H_ACT_OFS : 0.
  - o_y = v_in ? v_cnt-V_ACT_OFS : 0.
  - o_active = h_in & v_in & o_locked.
- o_frame_start: equals the vs_rise pulse, delayed one cycle (registered).
- FSM:
  - SEARCH -> MEASURE on the first vs_rise. Clears the mismatch flag and the frames-ok counter.
  - MEASURE:
    - Each hs_fall with h_cnt+1 different from the stored o_h_total (after the first line of the frame) sets the mismatch flag.
    - At vs_rise: if no mismatch and v_cnt+1 == stored o_v_total, increment frames-ok; else frames-ok<=0.
    - Mismatch is cleared at every vs_rise.
    - Moves to LOCKED when frames-ok reaches 2.
  - LOCKED: o_locked=1. Any line-length or frame-length mismatch -> MEASURE with frames-ok=0 and o_locked=0 the next cycle.
  - Any state: a timeout counter reaching TIMEOUT without hs_fall -> SEARCH. The counter is cleared by hs_fall.
- Syncs held permanently low (no edges): this is a timeout, not lock.
- Reset mid-frame: block returns to SEARCH and needs one vs_rise plus 2 matching frames to relock.

Optional Feature:
- Macro: VGA_SYNC_RX_META_EN.
- Defined: i_hs and i_vs each pass through a 2-flop synchronizer (reset to 1) before edge detection. All edge-to-counter latencies grow by 2 cycles. Use when the source is on a different clock.
- Undefined: inputs are used directly; the source must be synchronous to clk.

Decomposition:
- Package vga_pkg:
  - Default timing constants: 640x480 active, H_ACT_OFS, V_ACT_OFS, TIMEOUT.
  - Counter width localparam (11).
  - FSM state enum {SEARCH, MEASURE, LOCKED}.
- Sub-module vga_sync_edge: one per sync line. Contains the optional synchronizer, history flop and rise/fall pulse outputs.

Test Plan:
- Reset: assert reset mid-stream -> all outputs 0 immediately; after release, o_locked=0 until one vs_rise plus 2 matching frames.
- Nominal: source with 800-clock lines, HSYNC low for 96, active at 144 clocks after HSYNC fall, 525-line frames -> o_h_total=800, o_v_total=525, o_locked=1 after the third vs_rise.
- Pixel map: at the first active pixel -> o_x=0, o_y=0, o_active=1; at the last -> o_x=639, o_y=479; at x=640 -> o_active=0, o_x=0.
- Glitch: one line shortened to 799 clocks while locked -> o_locked=0 the next cycle; relock after 2 clean frames.
- Timeout: stop HSYNC for 4096 clocks -> FSM in SEARCH, o_locked=0, o_active=0.
- Coincident edges: vs_rise and hs_fall in the same cycle -> v_cnt=0, o_v_total includes that line, single o_frame_start pulse.
